// File: rtl/accum_ctrl_if.sv
// accum_ctrl_if: groups the pushbutton/operand inputs and the accumulator
// strobe outputs of accum_ctrl. The master side drives key/op/data, the
// slave side (accum_ctrl) drives the strobe, latched operation and status.
interface accum_ctrl_if;
  logic       key_n;
  logic [1:0] op_sel;
  logic [7:0] sw_data;
  logic       acc_en;
  logic [1:0] acc_op;
  logic [7:0] acc_operand;
  logic       busy;
  logic [7:0] press_count;

  modport master (
    output key_n,
    output op_sel,
    output sw_data,
    input  acc_en,
    input  acc_op,
    input  acc_operand,
    input  busy,
    input  press_count
  );

  modport slave (
    input  key_n,
    input  op_sel,
    input  sw_data,
    output acc_en,
    output acc_op,
    output acc_operand,
    output busy,
    output press_count
  );
endinterface

// File: rtl/accum_ctrl.sv
// accum_ctrl: debounced pushbutton controller that issues a one-cycle strobe
// to an accumulator datapath, carrying the operation and operand sampled on
// the strobe's entry edge. Optional auto-repeat of add/subtract while the key
// stays held is enabled by defining ACCUM_CTRL_AUTOREPEAT_EN; without it each
// accepted press yields exactly one strobe.
module accum_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  accum_ctrl_if.slave bus
);

  // One counter serves both debounce and repeat timing, so size it for the
  // larger of the two intervals.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef ACCUM_CTRL_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    FIRE       = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_meta_q, key_meta_d;
  logic          key_s_q, key_s_d;
  logic          acc_en_q, acc_en_d;
  logic [1:0]    acc_op_q, acc_op_d;
  logic [7:0]    acc_operand_q, acc_operand_d;
  logic          busy_q, busy_d;
  logic [7:0]    press_count_q, press_count_d;
  logic          fire;

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fire          = 1'b0;
    // Synchronizer stages; key is inverted so key_s = 1 means pressed.
    key_meta_d    = ~bus.key_n;
    key_s_d       = key_meta_q;

    unique case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = FIRE;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        state_d = HELD;
        cnt_d   = '0;
      end
      HELD: begin
        if (!key_s_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
`ifdef ACCUM_CTRL_AUTOREPEAT_EN
        // Only add/subtract repeat; the counter parks at its last value
        // for load/clear instead of wrapping.
        else if (cnt_q == REP_LAST) begin
          if (!acc_op_q[1]) begin
            state_d = FIRE;
            fire    = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE_DB: begin
        if (key_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Operands are captured only on the edge that enters FIRE.
    acc_en_d      = fire;
    acc_op_d      = fire ? bus.op_sel  : acc_op_q;
    acc_operand_d = fire ? bus.sw_data : acc_operand_q;
    busy_d        = (state_d != IDLE);
    press_count_d = press_count_q + 8'(acc_en_q);
  end

  // State, counter, synchronizer and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_meta_q    <= 1'b0;
      key_s_q       <= 1'b0;
      acc_en_q      <= 1'b0;
      acc_op_q      <= 2'b00;
      acc_operand_q <= 8'h00;
      busy_q        <= 1'b0;
      press_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_meta_q    <= key_meta_d;
      key_s_q       <= key_s_d;
      acc_en_q      <= acc_en_d;
      acc_op_q      <= acc_op_d;
      acc_operand_q <= acc_operand_d;
      busy_q        <= busy_d;
      press_count_q <= press_count_d;
    end
  end

  assign bus.acc_en      = acc_en_q;
  assign bus.acc_op      = acc_op_q;
  assign bus.acc_operand = acc_operand_q;
  assign bus.busy        = busy_q;
  assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// tb_accum_ctrl: scoreboard bench for accum_ctrl. Each press pushes the
// strobes it should produce (operation, operand, cycle); a monitor pops and
// compares them whenever acc_en is seen.
module tb_accum_ctrl;
  localparam int D = 4;
  localparam int R = 10;

  logic CLOCK_50;
  logic Resetn;
  accum_ctrl_if bus();

  accum_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       got_e;
  int         cyc;
  int         checks;
  int         errors;
  logic [7:0] exp_count;
  logic [1:0] exp_op;
  logic [7:0] exp_data;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Number of strobes a press held low for low_cycles edges should produce.
  function automatic int n_strobes(input logic [1:0] op, input int low_cycles);
    int n;
    n = (low_cycles >= D + 1) ? 1 : 0;
`ifdef ACCUM_CTRL_AUTOREPEAT_EN
    if (n == 1 && !op[1])
      for (int k = 1; D + 3 + k * (R + 1) <= low_cycles + 2; k++) n++;
`else
    if (op == 2'b11) n = n; // add/sub and load/clear behave alike here
`endif
    return n;
  endfunction

  task automatic push(input logic [1:0] op, input logic [7:0] data, input int at_cyc);
    exp_t e;
    e.op = op; e.data = data; e.cyc = at_cyc;
    sb.push_back(e);
    exp_count++;
    exp_op   = op;
    exp_data = data;
  endtask

  task automatic idle_check(input string name);
    check({name, "_busy_idle"},   32'(bus.busy), 0);
    check({name, "_press_count"}, 32'(bus.press_count), 32'(exp_count));
    check({name, "_acc_op"},      32'(bus.acc_op), 32'(exp_op));
    check({name, "_acc_operand"}, 32'(bus.acc_operand), 32'(exp_data));
    check({name, "_sb_drained"},  32'(sb.size()), 0);
  endtask

  // Press starting at a negedge; edge 1 is the next rising edge.
  task automatic press(input logic [1:0] op, input logic [7:0] data, input int low_cycles, input bit quiet);
    int n;
    int base;
    n = n_strobes(op, low_cycles);
    @(negedge CLOCK_50);
    bus.op_sel = op; bus.sw_data = data; bus.key_n = 1'b0;
    base = cyc;
    for (int k = 0; k < n; k++) push(op, data, base + D + 3 + k * (R + 1));
    repeat (low_cycles) @(negedge CLOCK_50);
    if (n > 0 && low_cycles > D + 4) check("busy_held", 32'(bus.busy), 1);
    bus.key_n = 1'b1; bus.op_sel = ~op; bus.sw_data = ~data;
    repeat (12) @(negedge CLOCK_50);
    if (!quiet)
      $display("press op=%0d data=%02h low=%0d expected_strobes=%0d press_count=%0d",
               op, data, low_cycles, n, bus.press_count);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge CLOCK_50) begin
    if (Resetn === 1'b1 && bus.acc_en !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(bus.acc_en), 0);
      end else begin
        got_e = sb.pop_front();
        check("strobe_cycle",   32'(cyc), 32'(got_e.cyc));
        check("strobe_op",      32'(bus.acc_op), 32'(got_e.op));
        check("strobe_operand", 32'(bus.acc_operand), 32'(got_e.data));
      end
    end
  end

  initial begin
    int base;
    checks = 0; errors = 0;
    exp_count = 8'h00; exp_op = 2'b00; exp_data = 8'h00;
    Resetn = 1'b0;
    bus.key_n = 1'b0; bus.op_sel = 2'b10; bus.sw_data = 8'hA5;

    // Reset with key held: outputs zero, then one strobe after full debounce.
    repeat (3) @(negedge CLOCK_50);
    check("rst_acc_en",      32'(bus.acc_en), 0);
    check("rst_acc_op",      32'(bus.acc_op), 0);
    check("rst_acc_operand", 32'(bus.acc_operand), 0);
    check("rst_busy",        32'(bus.busy), 0);
    check("rst_press_count", 32'(bus.press_count), 0);
    Resetn = 1'b1;
    base = cyc;
    push(2'b10, 8'hA5, base + D + 3);
    repeat (12) @(negedge CLOCK_50);
    bus.key_n = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    $display("reset-held press: press_count=%0d", bus.press_count);
    idle_check("after_reset_press");

    // Reset mid-debounce, key still held afterwards: counts as a new press.
    @(negedge CLOCK_50);
    bus.key_n = 1'b0; bus.op_sel = 2'b00; bus.sw_data = 8'h11;
    repeat (4) @(negedge CLOCK_50);
    check("busy_in_debounce", 32'(bus.busy), 1);
    Resetn = 1'b0;
    #1;
    check("async_rst_busy",        32'(bus.busy), 0);
    check("async_rst_press_count", 32'(bus.press_count), 0);
    exp_count = 8'h00; exp_op = 2'b00; exp_data = 8'h00;
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b1;
    base = cyc;
    push(2'b00, 8'h11, base + D + 3);
    repeat (12) @(negedge CLOCK_50);
    bus.key_n = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    $display("mid-debounce reset: press_count=%0d", bus.press_count);
    idle_check("mid_db_reset");

    // Clean add press.
    press(2'b00, 8'h05, 20, 1'b0);
    idle_check("add_press");

    // Short bounce: no strobe.
    press(2'b01, 8'h77, 2, 1'b0);
    idle_check("bounce");

    // Release glitch after a strobe: stays in HELD, no second strobe.
    @(negedge CLOCK_50);
    bus.op_sel = 2'b10; bus.sw_data = 8'h3C; bus.key_n = 1'b0;
    base = cyc;
    push(2'b10, 8'h3C, base + D + 3);
    repeat (10) @(negedge CLOCK_50);
    bus.key_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    bus.key_n = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    check("glitch_busy_held", 32'(bus.busy), 1);
    bus.key_n = 1'b1; bus.op_sel = 2'b01; bus.sw_data = 8'hC3;
    repeat (12) @(negedge CLOCK_50);
    $display("release glitch: press_count=%0d", bus.press_count);
    idle_check("glitch");

    // Long holds: subtract may repeat, clear never does.
    press(2'b01, 8'h21, 35, 1'b0);
    idle_check("sub_hold");
    press(2'b11, 8'h42, 35, 1'b0);
    idle_check("clr_hold");

    // Reset while HELD: abort, count cleared, no further strobe.
    @(negedge CLOCK_50);
    bus.op_sel = 2'b01; bus.sw_data = 8'h22; bus.key_n = 1'b0;
    base = cyc;
    push(2'b01, 8'h22, base + D + 3);
    repeat (10) @(negedge CLOCK_50);
    check("busy_before_held_reset", 32'(bus.busy), 1);
    Resetn = 1'b0;
    #1;
    check("held_rst_acc_en",      32'(bus.acc_en), 0);
    check("held_rst_busy",        32'(bus.busy), 0);
    check("held_rst_press_count", 32'(bus.press_count), 0);
    check("held_rst_acc_op",      32'(bus.acc_op), 0);
    check("held_rst_acc_operand", 32'(bus.acc_operand), 0);
    exp_count = 8'h00; exp_op = 2'b00; exp_data = 8'h00;
    bus.key_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    $display("held reset: press_count=%0d", bus.press_count);
    idle_check("held_reset");

    // Counter wrap: 256 presses return to 0, the 257th gives 1.
    for (int i = 0; i < 256; i++)
      press(2'($urandom_range(3)), 8'($urandom_range(255)), 8, 1'b1);
    $display("256 presses: press_count=%0d", bus.press_count);
    check("wrap_256", 32'(bus.press_count), 32'h00);
    press(2'b00, 8'h99, 8, 1'b0);
    check("wrap_257", 32'(bus.press_count), 32'h01);
    idle_check("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
